// File: rtl/alu_issue.sv
// Decode/issue stage feeding the EXU ALU: decodes RV32I OP/OP-IMM/LUI/AUIPC,
// reads the register file and hands registered operands on through a 2-entry skid buffer.
module alu_issue #(
   parameter int XLEN      = 32,
   parameter int RF_ADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          inst,
   input  logic [XLEN-1:0]      pc,
   output logic [RF_ADDR_W-1:0] rf_raddr1,
   output logic [RF_ADDR_W-1:0] rf_raddr2,
   input  logic [XLEN-1:0]      rf_rdata1,
   input  logic [XLEN-1:0]      rf_rdata2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      asrc1,
   output logic [XLEN-1:0]      asrc2,
   output logic [9:0]           funcEU,
   output logic [RF_ADDR_W-1:0] rd,
   output logic                 wen,
   output logic                 illegal
);

   // Handshake: a transfer happens on a side exactly when its valid and ready are
   // both high at a rising edge; the issued payload holds while out_valid & ~out_ready.

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic [XLEN-1:0]      a1;
      logic [XLEN-1:0]      a2;
      logic [9:0]           func;
      logic [RF_ADDR_W-1:0] rd;
      logic                 wen;
      logic                 illegal;
   } entry_t;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_t;

   buf_state_t state;
   buf_state_t next_state;
   entry_t     dec;
   entry_t     out_q;
   entry_t     skid_q;
   logic       legal;
   logic       accept;
   logic       issue;
   logic       load_out_dec;
   logic       load_out_skid;
   logic       load_skid;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode    = inst[6:0];
   assign funct3    = inst[14:12];
   assign funct7    = inst[31:25];
   assign rf_raddr1 = inst[19:15];
   assign rf_raddr2 = inst[24:20];

   always_comb begin
      dec    = '0;
      legal  = 1'b0;
      dec.rd = inst[11:7];
      case (opcode)
         OPC_OP: begin
            dec.func = {funct3, funct7};
            dec.a1   = rf_rdata1;
            dec.a2   = rf_rdata2;
            legal    = (funct7 == 7'h00) ||
                       ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
         end
         OPC_OP_IMM: begin
            dec.a1 = rf_rdata1;
            case (funct3)
               3'd1: begin
                  dec.a2   = {27'b0, inst[24:20]};
                  dec.func = {funct3, 7'h00};
                  legal    = (funct7 == 7'h00);
               end
               3'd5: begin
                  // Shift-right keeps funct7 so the ALU can tell SRAI from SRLI.
                  dec.a2   = {27'b0, inst[24:20]};
                  dec.func = {funct3, funct7};
                  legal    = (funct7 == 7'h00) || (funct7 == 7'h20);
               end
               default: begin
                  dec.a2   = {{20{inst[31]}}, inst[31:20]};
                  dec.func = {funct3, 7'h00};
                  legal    = 1'b1;
               end
            endcase
         end
         OPC_LUI: begin
            dec.a2 = {inst[31:12], 12'b0};
            legal  = 1'b1;
         end
         OPC_AUIPC: begin
            dec.a1 = pc;
            dec.a2 = {inst[31:12], 12'b0};
            legal  = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec.a1   = '0;
         dec.a2   = '0;
         dec.func = '0;
      end
      dec.illegal = ~legal;
      dec.wen     = legal && (inst[11:7] != 5'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= BUF_EMPTY;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (flush) begin
         next_state = BUF_EMPTY;
      end else begin
         case (state)
            BUF_EMPTY: if (accept) next_state = BUF_ONE;
            BUF_ONE: begin
               if (accept && !issue)      next_state = BUF_TWO;
               else if (!accept && issue) next_state = BUF_EMPTY;
            end
            BUF_TWO:   if (issue) next_state = BUF_ONE;
            default:   next_state = BUF_EMPTY;
         endcase
      end
   end

   always_comb begin
      out_valid     = (state != BUF_EMPTY) && !rst;
      in_ready      = (state != BUF_TWO) && !rst;
      accept        = in_valid && in_ready;
      issue         = out_valid && out_ready;
      load_out_dec  = accept && !flush &&
                      ((state == BUF_EMPTY) || ((state == BUF_ONE) && issue));
      load_out_skid = !flush && (state == BUF_TWO) && issue;
      load_skid     = accept && !flush && (state == BUF_ONE) && !issue;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out_dec)       out_q <= dec;
         else if (load_out_skid) out_q <= skid_q;
         if (load_skid)          skid_q <= dec;
      end
   end

   assign asrc1   = out_q.a1;
   assign asrc2   = out_q.a2;
   assign funcEU  = out_q.func;
   assign rd      = out_q.rd;
   assign wen     = out_q.wen;
   assign illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed literal cases followed by random traffic, all checked
// against a queue-based model of the in-flight instructions.
module tb_alu_issue;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [4:0]  rf_raddr1;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] asrc1;
   logic [31:0] asrc2;
   logic [9:0]  funcEU;
   logic [4:0]  rd;
   logic        wen;
   logic        illegal;

   typedef struct packed {
      logic [31:0] a1;
      logic [31:0] a2;
      logic [9:0]  f;
      logic [4:0]  rd;
      logic        wen;
      logic        ill;
   } ent_t;

   ent_t        exp_q[$];
   logic [31:0] rf[32];
   int          checks = 0;
   int          passes = 0;

   alu_issue dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .inst(inst), .pc(pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .out_valid(out_valid),
      .out_ready(out_ready), .asrc1(asrc1), .asrc2(asrc2), .funcEU(funcEU),
      .rd(rd), .wen(wen), .illegal(illegal)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : rf[rf_raddr1];
   assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : rf[rf_raddr2];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic logic [31:0] rf_at(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : rf[a];
   endfunction

   // Reference decode, written straight from the RV32I field rules.
   function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] p);
      ent_t       e;
      logic       ok;
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = ins[14:12];
      f7 = ins[31:25];
      e  = '0;
      ok = 1'b0;
      if (ins[6:0] == 7'h33) begin
         ok   = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
         e.f  = {f3, f7};
         e.a1 = rf_at(ins[19:15]);
         e.a2 = rf_at(ins[24:20]);
      end else if (ins[6:0] == 7'h13) begin
         e.a1 = rf_at(ins[19:15]);
         if (f3 == 3'd1 || f3 == 3'd5) begin
            e.a2 = 32'(ins[24:20]);
            ok   = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
            e.f  = {f3, (f3 == 3'd5) ? f7 : 7'h00};
         end else begin
            e.a2 = 32'($signed(ins[31:20]));
            ok   = 1'b1;
            e.f  = {f3, 7'h00};
         end
      end else if (ins[6:0] == 7'h37 || ins[6:0] == 7'h17) begin
         ok   = 1'b1;
         e.a1 = (ins[6:0] == 7'h17) ? p : 32'd0;
         e.a2 = ins & 32'hFFFF_F000;
      end
      if (!ok) e = '0;
      e.rd  = ins[11:7];
      e.ill = !ok;
      e.wen = ok && (ins[11:7] != 5'd0);
      return e;
   endfunction

   // Model: the buffer is just an ordered list of up to two accepted instructions.
   always @(posedge clk) begin
      logic acc;
      logic iss;
      if (rst || flush) begin
         exp_q.delete();
      end else begin
         acc = in_valid && (exp_q.size() < 2);
         iss = (exp_q.size() > 0) && out_ready;
         if (iss) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(ref_decode(inst, pc));
      end
   end

   // Scoreboard compare, every cycle, away from the rising edge.
   always @(negedge clk) begin
      logic exp_ov;
      logic exp_ir;
      exp_ov = !rst && (exp_q.size() > 0);
      exp_ir = !rst && (exp_q.size() < 2);
      check("out_valid", 128'(out_valid), 128'(exp_ov));
      check("in_ready", 128'(in_ready), 128'(exp_ir));
      check("rf_raddr", 128'({rf_raddr1, rf_raddr2}), 128'({inst[19:15], inst[24:20]}));
      if (exp_ov)
         check("payload{a1,a2,func,rd,wen,ill}",
               128'({asrc1, asrc2, funcEU, rd, wen, illegal}), 128'(exp_q[0]));
   end

   task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                        input logic ordy);
      in_valid  = v;
      inst      = i;
      pc        = p;
      out_ready = ordy;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] r;
      int          k;
      r = $urandom;
      k = $urandom_range(0, 9);
      if (k <= 2)      r[6:0] = 7'h33;
      else if (k <= 5) r[6:0] = 7'h13;
      else if (k == 6) r[6:0] = 7'h37;
      else if (k == 7) r[6:0] = 7'h17;
      else if (k == 9) begin
         r[6:0]   = 7'h33;
         r[14:12] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd5;
      end
      if (k <= 5 || k == 9) begin
         case ($urandom_range(0, 2))
            0:       r[31:25] = 7'h00;
            1:       r[31:25] = 7'h20;
            default: r[31:25] = r[31:25];
         endcase
      end
      return r;
   endfunction

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[1] = 32'd5;
      rf[2] = 32'd7;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset in_ready", 128'(in_ready), 128'(0));
      check("reset out_valid", 128'(out_valid), 128'(0));
      #1 rst = 1'b0;
      @(negedge clk);
      check("post-reset in_ready", 128'(in_ready), 128'(1));
      check("reset payload", 128'({asrc1, asrc2, funcEU, rd, wen, illegal}), 128'(0));
      #1;

      drive(1'b1, 32'h0020_81B3, 32'd0, 1'b1);
      @(negedge clk);
      check("add out_valid", 128'(out_valid), 128'(1));
      check("add fields", 128'({funcEU, asrc1, asrc2, rd, wen}),
            128'({10'h000, 32'd5, 32'd7, 5'd3, 1'b1}));
      #1 drive(1'b1, 32'hFFF0_0093, 32'd0, 1'b1);
      @(negedge clk);
      check("addi fields", 128'({funcEU, asrc1, asrc2, rd, wen}),
            128'({10'h000, 32'd0, 32'hFFFF_FFFF, 5'd1, 1'b1}));
      #1 drive(1'b1, 32'h4040_D113, 32'd0, 1'b1);
      @(negedge clk);
      check("srai fields", 128'({funcEU, asrc1, asrc2, rd}),
            128'({10'h2A0, 32'd5, 32'd4, 5'd2}));
      #1 drive(1'b1, 32'h4020_8133, 32'd0, 1'b1);
      @(negedge clk);
      check("sub fields", 128'({funcEU, asrc1, asrc2, illegal}),
            128'({10'h020, 32'd5, 32'd7, 1'b0}));
      #1 drive(1'b1, 32'h1234_5297, 32'h8000_0000, 1'b1);
      @(negedge clk);
      check("auipc fields", 128'({funcEU, asrc1, asrc2, rd}),
            128'({10'h000, 32'h8000_0000, 32'h1234_5000, 5'd5}));
      #1 drive(1'b1, 32'h0220_8133, 32'd0, 1'b1);
      @(negedge clk);
      check("mul illegal", 128'({illegal, wen, funcEU, asrc1, asrc2, rd}),
            128'({1'b1, 1'b0, 10'h000, 32'd0, 32'd0, 5'd2}));
      #1 drive(1'b0, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
      check("drained out_valid", 128'(out_valid), 128'(0));

      // Backpressure: two entries fill OUT and SKID, then drain in order.
      #1 drive(1'b1, 32'h0020_81B3, 32'd0, 1'b0);
      @(negedge clk);
      check("bp first in_ready", 128'(in_ready), 128'(1));
      #1 drive(1'b1, 32'h4020_8133, 32'd0, 1'b0);
      @(negedge clk);
      check("bp full in_ready", 128'(in_ready), 128'(0));
      check("bp frozen funcEU", 128'(funcEU), 128'(10'h000));
      #1 drive(1'b0, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
      check("bp second out", 128'({out_valid, in_ready, funcEU}), 128'({1'b1, 1'b1, 10'h020}));
      @(negedge clk);
      check("bp drained", 128'(out_valid), 128'(0));

      // Flush with both entries buffered, then flush against a same-cycle accept.
      #1 drive(1'b1, 32'h0020_81B3, 32'd0, 1'b0);
      @(negedge clk);
      #1 drive(1'b1, 32'h4020_8133, 32'd0, 1'b0);
      @(negedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      check("flush two out_valid", 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
      @(negedge clk);
      check("flush accept dropped", 128'(out_valid), 128'(0));
      #1 flush = 1'b0;

      // Reset mid-stream.
      drive(1'b1, 32'h0020_81B3, 32'd0, 1'b0);
      @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("mid rst outputs", 128'({out_valid, in_ready}), 128'(0));
      #1 begin rst = 1'b0; in_valid = 1'b0; end
      @(negedge clk);
      check("after rst no stale", 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
      #1;

      for (int c = 0; c < 3000; c++) begin
         rf[$urandom_range(1, 31)] = $urandom;
         drive($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 49) == 0);
         rst   = ($urandom_range(0, 199) == 0);
         @(negedge clk);
         #1;
      end
      rst = 1'b0;
      flush = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage that drives the EXU ALU.
- Accepts raw RV32I instructions over a valid/ready handshake and reads the register file combinationally.
- Encodes the ALU operation as funcEU = {funct3[2:0], funct7[6:0]} and delivers registered asrc1/asrc2/funcEU/rd to the execute stage through a 2-entry skid buffer.
- Covers OP, OP-IMM, LUI and AUIPC; every other opcode is flagged illegal.

Parameters:
- XLEN, 32, operand/PC width (only 32 supported)
- RF_ADDR_W, 5, register index width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous drop of all buffered entries
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- inst  in  32  instruction word
- pc  in  32  instruction address
- rf_raddr1  out  5  = inst[19:15], combinational
- rf_raddr2  out  5  = inst[24:20], combinational
- rf_rdata1  in  32  combinational RF read data 1 (x0 reads 0)
- rf_rdata2  in  32  combinational RF read data 2
- out_valid  out  1  issue entry valid
- out_ready  in  1  EXU accepts this cycle
- asrc1  out  32  ALU operand 1
- asrc2  out  32  ALU operand 2
- funcEU  out  10  {funct3, funct7} ALU op key
- rd  out  5  destination register
- wen  out  1  RF write enable for rd (0 when rd==0 or illegal)
- illegal  out  1  entry carries an undecodable instruction

Behaviour:
Handshakes:
- Accept when in_valid & in_ready.
- Issue when out_valid & out_ready.
- Payload is frozen while out_valid & ~out_ready.

Storage:
- Output register OUT plus one skid register SKID.
- in_ready = ~SKID.valid & ~rst (registered-state only; no combinational path from out_ready).

Latency and capture:
- 1 cycle: an instruction accepted in cycle N is visible on out_valid in cycle N+1 when OUT is empty or issuing.
- Operands and decode are captured at accept; later RF changes do not affect a buffered entry.

Buffer states, with transitions on accept (A) and issue (I):
- EMPTY: A -> ONE.
- ONE: A&I -> ONE (new entry in OUT); A&~I -> TWO (new entry to SKID); ~A&I -> EMPTY.
- TWO: I -> ONE (SKID moves to OUT); no accept possible.
- Full-throughput: A&I every cycle sustains 1 instruction/cycle with no bubble.

Decode (opcode inst[6:0]):
- OP 0110011:
  - funcEU = {inst[14:12], inst[31:25]}; asrc1 = rdata1, asrc2 = rdata2.
  - Legal only if funct7 = 0x00, or funct7 = 0x20 with funct3 ∈ {0, 5}.
- OP-IMM 0010011:
  - asrc1 = rdata1; asrc2 = sign-extended inst[31:20].
  - funct3 ∈ {0, 2, 3, 4, 6, 7}: funct7 field of funcEU forced to 0x00, regardless of imm bits.
  - funct3 = 1: asrc2 = {27'b0, inst[24:20]}; legal only if inst[31:25] = 0x00.
  - funct3 = 5: asrc2 = {27'b0, inst[24:20]}; funcEU funct7 = inst[31:25]; legal only if inst[31:25] ∈ {0x00, 0x20}.
- LUI 0110111: funcEU = 0x000 (add); asrc1 = 0; asrc2 = {inst[31:12], 12'b0}.
- AUIPC 0010111: funcEU = 0x000; asrc1 = pc; asrc2 = {inst[31:12], 12'b0}.
- Illegal instructions (other opcodes or a failed legality check):
  - illegal = 1, wen = 0, funcEU = 0, asrc1 = asrc2 = 0; rd still = inst[11:7].
  - The entry is still issued; no stall.
- wen = legal & (rd != 0).

Reset and flush:
- rst: OUT.valid = SKID.valid = 0; out_valid = 0, in_ready = 0 during reset and 1 the cycle after.
- Reset payload values: asrc1 = asrc2 = 0, funcEU = 0, rd = 0, wen = 0, illegal = 0.
- flush: both valids cleared next cycle and any same-cycle accept is discarded. Payload registers need not clear.
- Priority: rst > flush > normal operation.

Test Plan:
- Reset then `add x3,x1,x2` (0x002081B3) with rdata1 = 5, rdata2 = 7, out_ready = 1 -> next cycle out_valid = 1, funcEU = 0x000, asrc1 = 5, asrc2 = 7, rd = 3, wen = 1.
- `addi x1,x0,-1` (0xFFF00093) -> funcEU = 0x000 (funct7 not leaked from imm), asrc2 = 0xFFFFFFFF.
- `srai x2,x1,4` (0x4040D113) -> funcEU = 0x2A0, asrc2 = 4.
- `sub` (0x40208133) -> funcEU = 0x020.
- `auipc x5,0x12345` at pc = 0x80000000 -> asrc1 = 0x80000000, asrc2 = 0x12345000, funcEU = 0x000.
- Backpressure: out_ready = 0, send 2 instructions -> in_ready = 0 after the second accept. Then raise out_ready -> both issue in order on consecutive cycles and in_ready returns to 1.
- Illegal `mul` (0x02208133) -> illegal = 1, wen = 0, funcEU = 0.
- flush asserted with 2 entries buffered -> out_valid = 0 the next cycle.
- rst asserted mid-stream -> out_valid = 0 and in_ready = 0 during reset, and no stale entry appears afterwards.
